// File: rtl/ring_pkg.sv
// Shared types and default widths for the circular-buffer address controller.
// Holds only declarations; no logic, no latency.
package ring_pkg;

   localparam int RING_AW      = 15;
   localparam int RING_RW      = 10;
   localparam int RING_DW_DROP = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } ring_state_t;

endpackage

// File: rtl/ring_addr_ctrl_if.sv
// Control/address bundle between the ring controller (slave side) and its driver.
// Pure wiring; no latency and no backpressure of its own.
interface ring_addr_ctrl_if
   import ring_pkg::*;
#(
   parameter int AW      = RING_AW,
   parameter int RW      = RING_RW,
   parameter int DW_DROP = RING_DW_DROP
) ();

   logic               run;
   logic [AW-1:0]      limit;
   logic               wr_en;
   logic               rd_req;
   logic [AW-1:0]      wr_addr;
   logic [AW-1:0]      rd_addr;
   logic               ram_we;
   logic [RW-1:0]      n1;
   logic [RW-1:0]      n2;
   logic               rd_valid;
   logic               full;
   logic               empty;
   logic               busy;
   logic [DW_DROP-1:0] drop_cnt;

   modport slave (
      input  run, limit, wr_en, rd_req,
      output wr_addr, rd_addr, ram_we, n1, n2, rd_valid, full, empty, busy, drop_cnt
   );

   modport master (
      output run, limit, wr_en, rd_req,
      input  wr_addr, rd_addr, ram_we, n1, n2, rd_valid, full, empty, busy, drop_cnt
   );

endinterface

// File: rtl/ring_ptr.sv
// Wrapping address pointer with round counter; advances one cycle after inc.
// Never stalls: the caller gates inc, and clr has priority over inc.
module ring_ptr #(
   parameter int AW = 15,
   parameter int RW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          clr,
   input  logic [AW-1:0] limit_q,
   output logic [AW-1:0] addr,
   output logic [RW-1:0] rounds
);

   logic [AW-1:0] r_addr;
   logic [RW-1:0] r_rounds;
   logic          w_wrap;

   // limit_q==1 makes every accept a wrap: address pinned at 0, rounds count each access.
   assign w_wrap = (r_addr == limit_q - AW'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr   <= '0;
         r_rounds <= '0;
      end else if (clr) begin
         r_addr   <= '0;
         r_rounds <= '0;
      end else if (inc) begin
         if (w_wrap) begin
            r_addr   <= '0;
            r_rounds <= r_rounds + RW'(1);
         end else begin
            r_addr   <= r_addr + AW'(1);
         end
      end
   end

   assign addr   = r_addr;
   assign rounds = r_rounds;

endmodule

// File: rtl/ring_addr_ctrl.sv
// Write/read pointer and round-count generator for one circular RAM buffer.
// ram_we is same-cycle, rd_valid follows RD_LAT cycles later; writes stall on full, reads on empty.
module ring_addr_ctrl
   import ring_pkg::*;
#(
   parameter int AW      = RING_AW,
   parameter int RW      = RING_RW,
   parameter int RD_LAT  = 1,
   parameter int DW_DROP = RING_DW_DROP
) (
   input  logic     clk,
   input  logic     reset,
   ring_addr_ctrl_if.slave bus
);

   ring_state_t        r_state;
   ring_state_t        w_state_nxt;
   logic [AW-1:0]      r_limit_q;
   logic [AW-1:0]      w_limit_nxt;
   logic [AW:0]        r_occ;
   logic [AW:0]        w_occ_nxt;
   logic               r_full;
   logic               r_empty;
   logic [DW_DROP-1:0] r_drop;
   logic [RD_LAT-1:0]  r_rv;
   logic               w_wr_acc;
   logic               w_rd_acc;
   logic               w_clr;
   logic               w_drop_hit;
   logic [AW-1:0]      w_wr_addr;
   logic [AW-1:0]      w_rd_addr;
   logic [RW-1:0]      w_n1;
   logic [RW-1:0]      w_n2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_limit_nxt = r_limit_q;
      w_wr_acc    = 1'b0;
      w_rd_acc    = 1'b0;
      w_clr       = 1'b0;
      w_drop_hit  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_limit_nxt = (bus.limit == '0) ? AW'(1) : bus.limit;
            if (bus.run) begin
               w_state_nxt = ST_RUN;
               w_clr       = 1'b1;
            end
         end
         ST_RUN: begin
            w_wr_acc   = bus.wr_en & ~r_full;
            w_drop_hit = bus.wr_en & r_full;
            w_rd_acc   = bus.rd_req & ~r_empty;
            if (!bus.run) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_rd_acc = bus.rd_req & ~r_empty;
            // Leave only once the last read's data has come back out of the RAM.
            if (bus.run)                              w_state_nxt = ST_RUN;
            else if (r_occ == '0 && r_rv == '0)       w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_occ_nxt = r_occ;
      if (w_clr)                     w_occ_nxt = '0;
      else if (w_wr_acc & ~w_rd_acc) w_occ_nxt = r_occ + (AW+1)'(1);
      else if (w_rd_acc & ~w_wr_acc) w_occ_nxt = r_occ - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_limit_q <= AW'(1);
         r_occ     <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_drop    <= '0;
         r_rv      <= '0;
      end else begin
         r_limit_q <= w_limit_nxt;
         r_occ     <= w_occ_nxt;
         r_full    <= (w_occ_nxt == {1'b0, w_limit_nxt});
         r_empty   <= (w_occ_nxt == '0);
         r_rv      <= (r_rv << 1) | RD_LAT'(w_rd_acc);
         if (w_clr)                      r_drop <= '0;
         else if (w_drop_hit && !(&r_drop)) r_drop <= r_drop + DW_DROP'(1);
      end
   end

   ring_ptr #(.AW(AW), .RW(RW)) u_wr_ptr (
      .clk     (clk),
      .reset   (reset),
      .inc     (w_wr_acc),
      .clr     (w_clr),
      .limit_q (r_limit_q),
      .addr    (w_wr_addr),
      .rounds  (w_n1)
   );

   ring_ptr #(.AW(AW), .RW(RW)) u_rd_ptr (
      .clk     (clk),
      .reset   (reset),
      .inc     (w_rd_acc),
      .clr     (w_clr),
      .limit_q (r_limit_q),
      .addr    (w_rd_addr),
      .rounds  (w_n2)
   );

   assign bus.ram_we   = w_wr_acc;
   assign bus.wr_addr  = w_wr_addr;
   assign bus.rd_addr  = w_rd_addr;
   assign bus.n1       = w_n1;
   assign bus.n2       = w_n2;
   assign bus.rd_valid = r_rv[RD_LAT-1];
   assign bus.full     = r_full;
   assign bus.empty    = r_empty;
   assign bus.busy     = (r_state != ST_IDLE);
   assign bus.drop_cnt = r_drop;

endmodule

// File: tb/tb_ring_addr_ctrl.sv
// Directed bench for ring_addr_ctrl: fill, drain, streaming, DRAIN state, depth-1 and reset cases.
module tb_ring_addr_ctrl;

   localparam int AW = 15;
   localparam int RW = 10;
   localparam int DW = 16;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   ring_addr_ctrl_if #(.AW(AW), .RW(RW), .DW_DROP(DW)) bus ();

   ring_addr_ctrl #(.AW(AW), .RW(RW), .RD_LAT(1), .DW_DROP(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset(input string tag);
      #1;
      n_cmp++; if (bus.wr_addr  !== '0)   begin n_bad++; $display("FAIL %s wr_addr got %0d want 0", tag, bus.wr_addr); end
      n_cmp++; if (bus.rd_addr  !== '0)   begin n_bad++; $display("FAIL %s rd_addr got %0d want 0", tag, bus.rd_addr); end
      n_cmp++; if (bus.n1       !== '0)   begin n_bad++; $display("FAIL %s n1 got %0d want 0", tag, bus.n1); end
      n_cmp++; if (bus.n2       !== '0)   begin n_bad++; $display("FAIL %s n2 got %0d want 0", tag, bus.n2); end
      n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL %s rd_valid got %b want 0", tag, bus.rd_valid); end
      n_cmp++; if (bus.ram_we   !== 1'b0) begin n_bad++; $display("FAIL %s ram_we got %b want 0", tag, bus.ram_we); end
      n_cmp++; if (bus.full     !== 1'b0) begin n_bad++; $display("FAIL %s full got %b want 0", tag, bus.full); end
      n_cmp++; if (bus.empty    !== 1'b1) begin n_bad++; $display("FAIL %s empty got %b want 1", tag, bus.empty); end
      n_cmp++; if (bus.busy     !== 1'b0) begin n_bad++; $display("FAIL %s busy got %b want 0", tag, bus.busy); end
      n_cmp++; if (bus.drop_cnt !== '0)   begin n_bad++; $display("FAIL %s drop_cnt got %0d want 0", tag, bus.drop_cnt); end
   endtask

   // Drops run, then waits (bounded) for the controller to settle back in IDLE.
   task automatic go_idle(input string tag);
      bit done;
      done = 1'b0;
      bus.run = 1'b0; bus.wr_en = 1'b0; bus.rd_req = 1'b0;
      for (int i = 0; i < 12 && !done; i++) begin
         cyc();
         if (bus.busy === 1'b0) done = 1'b1;
      end
      n_cmp++; if (!done) begin n_bad++; $display("FAIL %s idle_timeout busy got %b want 0", tag, bus.busy); end
   endtask

   task automatic start_run(input logic [AW-1:0] lim);
      bus.limit = lim; bus.run = 1'b1; bus.wr_en = 1'b0; bus.rd_req = 1'b0;
      cyc();
   endtask

   task automatic test_fill();
      start_run(15'd4);
      for (int i = 0; i < 6; i++) begin
         bus.wr_en = 1'b1;
         #1;
         n_cmp++; if (bus.ram_we !== (i < 4)) begin n_bad++; $display("FAIL fill ram_we[%0d] got %b want %b", i, bus.ram_we, (i < 4)); end
         if (i < 4) begin
            n_cmp++; if (bus.wr_addr !== AW'(i)) begin n_bad++; $display("FAIL fill wr_addr[%0d] got %0d want %0d", i, bus.wr_addr, i); end
         end
         cyc();
      end
      bus.wr_en = 1'b0;
      #1;
      n_cmp++; if (bus.n1 !== RW'(1))       begin n_bad++; $display("FAIL fill n1 got %0d want 1", bus.n1); end
      n_cmp++; if (bus.full !== 1'b1)       begin n_bad++; $display("FAIL fill full got %b want 1", bus.full); end
      n_cmp++; if (bus.drop_cnt !== DW'(2)) begin n_bad++; $display("FAIL fill drop_cnt got %0d want 2", bus.drop_cnt); end
      n_cmp++; if (bus.wr_addr !== '0)      begin n_bad++; $display("FAIL fill wr_addr_end got %0d want 0", bus.wr_addr); end
   endtask

   task automatic test_read_out();
      for (int i = 0; i < 4; i++) begin
         bus.rd_req = 1'b1;
         #1;
         n_cmp++; if (bus.rd_addr !== AW'(i))    begin n_bad++; $display("FAIL read rd_addr[%0d] got %0d want %0d", i, bus.rd_addr, i); end
         n_cmp++; if (bus.rd_valid !== (i > 0)) begin n_bad++; $display("FAIL read rd_valid[%0d] got %b want %b", i, bus.rd_valid, (i > 0)); end
         cyc();
      end
      bus.rd_req = 1'b0;
      #1;
      n_cmp++; if (bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL read rd_valid_last got %b want 1", bus.rd_valid); end
      cyc();
      n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL read rd_valid_off got %b want 0", bus.rd_valid); end
      n_cmp++; if (bus.n2 !== RW'(1))     begin n_bad++; $display("FAIL read n2 got %0d want 1", bus.n2); end
      n_cmp++; if (bus.empty !== 1'b1)    begin n_bad++; $display("FAIL read empty got %b want 1", bus.empty); end
      n_cmp++; if (bus.full !== 1'b0)     begin n_bad++; $display("FAIL read full got %b want 0", bus.full); end
   endtask

   task automatic test_back_to_back();
      go_idle("b2b");
      start_run(15'd3);
      bus.wr_en = 1'b1;
      cyc();
      bus.rd_req = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         n_cmp++; if (bus.wr_addr !== AW'((k + 1) % 3)) begin n_bad++; $display("FAIL b2b wr_addr[%0d] got %0d want %0d", k, bus.wr_addr, (k + 1) % 3); end
         n_cmp++; if (bus.rd_addr !== AW'(k % 3))       begin n_bad++; $display("FAIL b2b rd_addr[%0d] got %0d want %0d", k, bus.rd_addr, k % 3); end
         n_cmp++; if (bus.ram_we !== 1'b1)              begin n_bad++; $display("FAIL b2b ram_we[%0d] got %b want 1", k, bus.ram_we); end
         cyc();
      end
      bus.wr_en = 1'b0; bus.rd_req = 1'b0;
      #1;
      n_cmp++; if (bus.n1 !== RW'(7))    begin n_bad++; $display("FAIL b2b n1 got %0d want 7", bus.n1); end
      n_cmp++; if (bus.n2 !== RW'(6))    begin n_bad++; $display("FAIL b2b n2 got %0d want 6", bus.n2); end
      n_cmp++; if (bus.empty !== 1'b0)   begin n_bad++; $display("FAIL b2b empty got %b want 0", bus.empty); end
      n_cmp++; if (bus.full !== 1'b0)    begin n_bad++; $display("FAIL b2b full got %b want 0", bus.full); end
      n_cmp++; if (bus.drop_cnt !== '0)  begin n_bad++; $display("FAIL b2b drop_cnt got %0d want 0", bus.drop_cnt); end
   endtask

   task automatic test_drain();
      bit done;
      bus.wr_en = 1'b1;
      cyc(); cyc();
      bus.wr_en = 1'b0;
      #1;
      n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL drain full_pre got %b want 1", bus.full); end
      bus.run = 1'b0;
      cyc();
      bus.wr_en = 1'b1;
      #1;
      n_cmp++; if (bus.busy !== 1'b1)   begin n_bad++; $display("FAIL drain busy got %b want 1", bus.busy); end
      for (int i = 0; i < 3; i++) begin
         bus.rd_req = 1'b1;
         #1;
         n_cmp++; if (bus.ram_we !== 1'b0) begin n_bad++; $display("FAIL drain ram_we[%0d] got %b want 0", i, bus.ram_we); end
         cyc();
      end
      bus.rd_req = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (bus.busy === 1'b0) done = 1'b1;
         else cyc();
      end
      n_cmp++; if (!done)                begin n_bad++; $display("FAIL drain idle_timeout busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.drop_cnt !== '0)  begin n_bad++; $display("FAIL drain drop_cnt got %0d want 0", bus.drop_cnt); end
      n_cmp++; if (bus.empty !== 1'b1)   begin n_bad++; $display("FAIL drain empty got %b want 1", bus.empty); end
      bus.wr_en = 1'b0;
   endtask

   task automatic test_limit_zero();
      go_idle("lim0");
      start_run(15'd0);
      for (int i = 0; i < 3; i++) begin
         bus.wr_en = 1'b1;
         #1;
         n_cmp++; if (bus.wr_addr !== '0)  begin n_bad++; $display("FAIL lim0 wr_addr[%0d] got %0d want 0", i, bus.wr_addr); end
         n_cmp++; if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL lim0 ram_we[%0d] got %b want 1", i, bus.ram_we); end
         cyc();
         bus.wr_en = 1'b0;
         n_cmp++; if (bus.full !== 1'b1)   begin n_bad++; $display("FAIL lim0 full[%0d] got %b want 1", i, bus.full); end
         bus.rd_req = 1'b1;
         #1;
         n_cmp++; if (bus.rd_addr !== '0)  begin n_bad++; $display("FAIL lim0 rd_addr[%0d] got %0d want 0", i, bus.rd_addr); end
         cyc();
         bus.rd_req = 1'b0;
      end
      #1;
      n_cmp++; if (bus.n1 !== RW'(3))  begin n_bad++; $display("FAIL lim0 n1 got %0d want 3", bus.n1); end
      n_cmp++; if (bus.n2 !== RW'(3))  begin n_bad++; $display("FAIL lim0 n2 got %0d want 3", bus.n2); end
      n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL lim0 empty got %b want 1", bus.empty); end
   endtask

   task automatic test_reset_mid();
      go_idle("rstmid");
      start_run(15'd8);
      bus.wr_en = 1'b1;
      repeat (5) cyc();
      bus.wr_en = 1'b0; bus.rd_req = 1'b1;
      cyc();
      bus.rd_req = 1'b0;
      n_cmp++; if (bus.rd_valid !== 1'b1)  begin n_bad++; $display("FAIL rstmid rd_valid_pre got %b want 1", bus.rd_valid); end
      n_cmp++; if (bus.wr_addr !== AW'(5)) begin n_bad++; $display("FAIL rstmid wr_addr_pre got %0d want 5", bus.wr_addr); end
      bus.wr_en = 1'b1;
      reset = 1'b0;
      test_reset("rstmid");
      bus.run = 1'b0; bus.wr_en = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      reset = 1'b0;
      bus.run = 1'b0; bus.limit = '0; bus.wr_en = 1'b0; bus.rd_req = 1'b0;
      cyc(); cyc();
      test_reset("rst");
      reset = 1'b1;
      cyc();
      test_fill();
      test_read_out();
      test_back_to_back();
      test_drain();
      test_limit_zero();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
